// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: state encoding used by the
// control FSM in countdown_timer.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_EXPIRED = 2'd2
    } timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for countdown_timer: counts 0..PRESCALE-1 while enabled and flags
// the wrap cycle; the count is held while disabled and zeroed by clear.
module timer_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic wrap
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] r_count;

    assign wrap = en && (r_count == LAST);

    // prescale counter; a held count lets a stopped timer resume mid-period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= wrap ? '0 : (r_count + ONE);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Prescaled countdown timer with start/stop/ack control and sticky expiry flag.
// Periodic auto-reload is built only when COUNTDOWN_TIMER_AUTO_RELOAD_EN is defined.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 1_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             ack,
    input  logic             periodic,
    output logic [WIDTH-1:0] value,
    output logic             running,
    output logic             expired,
    output logic             tick
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    timer_state_t     r_state;
    timer_state_t     w_state_nx;
    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] w_value_nx;
    logic             r_running;
    logic             r_expired;
    logic             w_expired_nx;
    logic             r_tick;
    logic             w_tick_nx;
    logic             w_set_exp;
    logic             w_en;
    logic             w_wrap;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nx;
`else
    logic             w_unused_periodic;
    assign w_unused_periodic = periodic;
`endif

    // stop and load both freeze the prescaler in the cycle they are seen
    assign w_en = (r_state == ST_RUNNING) && !stop && !load;

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (w_en),
        .clear (load),
        .wrap  (w_wrap)
    );

    // next-state and next-output logic
    always_comb begin
        w_state_nx  = r_state;
        w_value_nx  = r_value;
        w_tick_nx   = 1'b0;
        w_set_exp   = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        w_reload_nx = r_reload;
`endif
        if (load) begin
            w_value_nx = load_value;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            w_reload_nx = load_value;
`endif
            if (start && !stop && (load_value != '0)) begin
                w_state_nx = ST_RUNNING;
            end else begin
                w_state_nx = ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop && (r_value != '0)) begin
                        w_state_nx = ST_RUNNING;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
                ST_RUNNING: begin
                    if (stop) begin
                        w_state_nx = ST_IDLE;
                    end else if (w_wrap) begin
                        if (r_value == ONE) begin
                            w_tick_nx = 1'b1;
                            w_set_exp = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                            if (periodic) begin
                                w_value_nx = r_reload;
                            end else begin
                                w_value_nx = '0;
                                w_state_nx = ST_EXPIRED;
                            end
`else
                            w_value_nx = '0;
                            w_state_nx = ST_EXPIRED;
`endif
                        end else begin
                            w_value_nx = r_value - ONE;
                        end
                    end else begin
                        w_state_nx = ST_RUNNING;
                    end
                end
                ST_EXPIRED: begin
                    if (ack) begin
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_state_nx = ST_EXPIRED;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end

        // a fresh expiry outranks an ack arriving in the same cycle
        if (w_set_exp) begin
            w_expired_nx = 1'b1;
        end else if (ack) begin
            w_expired_nx = 1'b0;
        end else begin
            w_expired_nx = r_expired;
        end
    end

    // state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_value   <= '0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_value   <= w_value_nx;
            r_running <= (w_state_nx == ST_RUNNING);
            r_expired <= w_expired_nx;
            r_tick    <= w_tick_nx;
        end
    end

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    // reload register for periodic mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reload <= '0;
        end else begin
            r_reload <= w_reload_nx;
        end
    end
`endif

    assign value   = r_value;
    assign running = r_running;
    assign expired = r_expired;
    assign tick    = r_tick;

endmodule
